// File: rtl/pe_row_sad.sv
// One row of a SAD processing array: double-buffered current pixels, a loadable/shiftable
// reference row, and an FSM that accumulates ROWS row sums into one block SAD.
module pe_row_sad #(
  parameter int PIXEL  = 8,
  parameter int NUM_PE = 8,
  parameter int ROWS   = 8,
  parameter int SAD_W  = PIXEL + $clog2(NUM_PE * ROWS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      curr_load,
  input  logic                      curr_bank_wr,
  input  logic                      curr_bank_rd,
  input  logic [PIXEL*NUM_PE-1:0]   curr_in,
  input  logic [1:0]                ref_mode,
  input  logic [PIXEL*NUM_PE-1:0]   ref_in_ext,
  input  logic [PIXEL*NUM_PE-1:0]   ref_in_down,
  input  logic [PIXEL-1:0]          ref_in_side,
  input  logic                      start,
  input  logic                      acc_en,
  output logic                      busy,
  output logic                      sad_valid,
  output logic [SAD_W-1:0]          sad_out,
  output logic [PIXEL*NUM_PE-1:0]   ref_out
);

  localparam int RS_W  = PIXEL + $clog2(NUM_PE);
  localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  logic [NUM_PE-1:0][PIXEL-1:0] curr0_q, curr0_d;
  logic [NUM_PE-1:0][PIXEL-1:0] curr1_q, curr1_d;
  logic [NUM_PE-1:0][PIXEL-1:0] ref_q, ref_d;
  logic [NUM_PE-1:0][PIXEL-1:0] diff;
  logic [RS_W-1:0]              row_sum;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SAD_W-1:0] acc_q, acc_d;
  logic [SAD_W-1:0] sad_q, sad_d;
  logic [SAD_W-1:0] acc_plus_row;

  // Storage next-state: bank writes and reference moves run regardless of the FSM.
  always_comb begin
    curr0_d = curr0_q;
    curr1_d = curr1_q;
    ref_d   = ref_q;
    if (curr_load && !curr_bank_wr) curr0_d = curr_in;
    if (curr_load &&  curr_bank_wr) curr1_d = curr_in;
    case (ref_mode)
      2'b01: ref_d = ref_in_ext;
      2'b10: ref_d = ref_in_down;
      2'b11: begin
        for (int i = 0; i < NUM_PE - 1; i++) ref_d[i] = ref_q[i+1];
        ref_d[NUM_PE-1] = ref_in_side;
      end
      default: ref_d = ref_q;
    endcase
  end

  generate
    for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_pe
      logic [PIXEL-1:0] cur_px;
      assign cur_px   = curr_bank_rd ? curr1_q[gi] : curr0_q[gi];
      assign diff[gi] = (cur_px > ref_q[gi]) ? (cur_px - ref_q[gi]) : (ref_q[gi] - cur_px);
      assign ref_out[gi*PIXEL +: PIXEL] = ref_q[gi];
    end
  endgenerate

  always_comb begin
    row_sum = '0;
    for (int i = 0; i < NUM_PE; i++) row_sum = row_sum + RS_W'(diff[i]);
  end

  assign acc_plus_row = acc_q + SAD_W'(row_sum);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sad_d   = sad_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACC;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      ACC: begin
        if (acc_en) begin
          acc_d = acc_plus_row;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ROWS - 1)) begin
            state_d = DONE;
            sad_d   = acc_plus_row;
            cnt_d   = '0;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      curr0_q <= '0;
      curr1_q <= '0;
      ref_q   <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      sad_q   <= '0;
    end else begin
      curr0_q <= curr0_d;
      curr1_q <= curr1_d;
      ref_q   <= ref_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sad_q   <= sad_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign sad_valid = (state_q == DONE);
  assign sad_out   = sad_q;

endmodule

// File: tb/tb_pe_row_sad.sv
// Scenario bench for pe_row_sad: expected SADs are queued at start and checked on sad_valid.
module tb_pe_row_sad;
  localparam int PIXEL  = 8;
  localparam int NUM_PE = 8;
  localparam int ROWS   = 8;
  localparam int SAD_W  = 14;
  localparam int W      = PIXEL * NUM_PE;

  logic             clk = 0;
  logic             rst, curr_load, curr_bank_wr, curr_bank_rd;
  logic [W-1:0]     curr_in, ref_in_ext, ref_in_down;
  logic [1:0]       ref_mode;
  logic [PIXEL-1:0] ref_in_side;
  logic             start, acc_en;
  logic             busy, sad_valid;
  logic [SAD_W-1:0] sad_out;
  logic [W-1:0]     ref_out;

  int tests_run = 0;
  int tests_failed = 0;
  logic [SAD_W-1:0] sb_q[$];
  logic [W-1:0] cur_m[2];
  logic [W-1:0] ref_m;

  pe_row_sad #(.PIXEL(PIXEL), .NUM_PE(NUM_PE), .ROWS(ROWS), .SAD_W(SAD_W)) dut (
    .clk(clk), .rst(rst), .curr_load(curr_load), .curr_bank_wr(curr_bank_wr),
    .curr_bank_rd(curr_bank_rd), .curr_in(curr_in), .ref_mode(ref_mode),
    .ref_in_ext(ref_in_ext), .ref_in_down(ref_in_down), .ref_in_side(ref_in_side),
    .start(start), .acc_en(acc_en), .busy(busy), .sad_valid(sad_valid),
    .sad_out(sad_out), .ref_out(ref_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every sad_valid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (sad_valid === 1'b1) begin
      tests_run++;
      if (sb_q.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_unexpected_valid: sad_out=%0d, required no sad_valid", sad_out);
      end else begin
        logic [SAD_W-1:0] exp_v;
        exp_v = sb_q.pop_front();
        if (sad_out !== exp_v) begin
          tests_failed++;
          $display("FAIL sb_sad_out: got %0d, required %0d", sad_out, exp_v);
        end else begin
          $display("[TB] sad_valid sad_out=%0d ok", sad_out);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rep(input int p);
    logic [W-1:0] v;
    for (int i = 0; i < NUM_PE; i++) v[i*PIXEL +: PIXEL] = PIXEL'(p);
    return v;
  endfunction

  function automatic logic [W-1:0] rand_row();
    logic [W-1:0] v;
    for (int i = 0; i < NUM_PE; i++) v[i*PIXEL +: PIXEL] = PIXEL'($urandom_range(0, 255));
    return v;
  endfunction

  function automatic int model_sad(input logic [W-1:0] c, input logic [W-1:0] r);
    int s = 0;
    int a, b;
    for (int i = 0; i < NUM_PE; i++) begin
      a = int'(c[i*PIXEL +: PIXEL]);
      b = int'(r[i*PIXEL +: PIXEL]);
      s += (a > b) ? a - b : b - a;
    end
    return s * ROWS;
  endfunction

  task automatic load_bank(input bit bank, input logic [W-1:0] v);
    curr_load = 1; curr_bank_wr = bank; curr_in = v;
    tick();
    curr_load = 0;
    cur_m[bank] = v;
  endtask

  task automatic set_ref(input logic [W-1:0] v);
    ref_mode = 2'b01; ref_in_ext = v;
    tick();
    ref_mode = 2'b00;
    ref_m = v;
  endtask

  // Pulses start for one edge.
  task automatic fire_start();
    start = 1;
    tick();
    start = 0;
  endtask

  // Counts edges until sad_valid appears, noting any cycle where busy dropped early.
  task automatic wait_valid(output int k, output bit busy_bad);
    k = 0; busy_bad = 0;
    while (k < 60) begin
      tick();
      k++;
      if (sad_valid === 1'b1) break;
      if (busy !== 1'b1) busy_bad = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1; tick(); tick();
    rst = 0;
    tests_run++;
    if (busy !== 1'b0 || sad_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: busy=%b sad_valid=%b, required 0 0", busy, sad_valid);
    end
    tests_run++;
    if (sad_out !== '0 || ref_out !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: sad_out=%0d ref_out=%h, required 0 0", sad_out, ref_out);
    end
    cur_m[0] = '0; cur_m[1] = '0; ref_m = '0;
    $display("[TB] reset done");
  endtask

  task automatic test_basic();
    int k; bit bb;
    load_bank(0, rep(15)); load_bank(1, rep(15));
    set_ref(rep(1));
    curr_bank_rd = 0;
    sb_q.push_back(SAD_W'(896));
    fire_start();
    wait_valid(k, bb);
    tests_run++;
    if (k !== ROWS || sad_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_latency: edges=%0d, required %0d", k, ROWS);
    end
    tests_run++;
    if (bb) begin
      tests_failed++;
      $display("FAIL basic_busy: busy dropped during ACC, required 1");
    end
    tick();
    tests_run++;
    if (sad_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_pulse: sad_valid=%b busy=%b, required 0 0", sad_valid, busy);
    end
    tick(); tick();
    tests_run++;
    if (sad_out !== SAD_W'(896)) begin
      tests_failed++;
      $display("FAIL basic_hold: sad_out=%0d, required 896", sad_out);
    end
  endtask

  task automatic test_max();
    int k; bit bb;
    load_bank(0, rep(255));
    set_ref(rep(0));
    curr_bank_rd = 0;
    sb_q.push_back(SAD_W'(16320));
    fire_start();
    wait_valid(k, bb);
    tests_run++;
    if (k !== ROWS) begin
      tests_failed++;
      $display("FAIL max_latency: edges=%0d, required %0d", k, ROWS);
    end
    tick();
  endtask

  task automatic test_stall();
    int k; bit bb;
    bit busy_low;
    load_bank(0, rep(15));
    set_ref(rep(1));
    sb_q.push_back(SAD_W'(896));
    fire_start();
    tick(); tick();
    acc_en = 0;
    busy_low = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (busy !== 1'b1 || sad_valid !== 1'b0) busy_low = 1;
    end
    acc_en = 1;
    wait_valid(k, bb);
    tests_run++;
    if (k + 5 !== ROWS + 3) begin
      tests_failed++;
      $display("FAIL stall_latency: edges=%0d, required %0d", k + 5, ROWS + 3);
    end
    tests_run++;
    if (bb || busy_low) begin
      tests_failed++;
      $display("FAIL stall_busy: busy low or early valid during stall, required busy 1");
    end
    tick();
  endtask

  task automatic test_bank_select();
    int k;
    bit got;
    load_bank(0, rep(15)); load_bank(1, rep(7));
    set_ref(rep(1));
    curr_bank_rd = 1;
    sb_q.push_back(SAD_W'(384));
    fire_start();
    k = 0; got = 0;
    while (k < 40 && !got) begin
      start = (k == 3);
      tick();
      k++;
      if (sad_valid === 1'b1) got = 1;
    end
    tests_run++;
    if (!got || k !== ROWS) begin
      tests_failed++;
      $display("FAIL banksel_latency: edges=%0d got=%b, required %0d", k, got, ROWS);
    end
    start = 1;
    tick();
    start = 0;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL banksel_start_in_done: busy=%b, required 0", busy);
    end
    for (int i = 0; i < ROWS + 4; i++) tick();
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL banksel_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_ref_modes();
    logic [W-1:0] seq, exp_v, down;
    for (int i = 0; i < NUM_PE; i++) seq[i*PIXEL +: PIXEL] = PIXEL'(i);
    set_ref(seq);
    ref_mode = 2'b11; ref_in_side = 8'd9;
    tick();
    ref_mode = 2'b00;
    for (int i = 0; i < NUM_PE; i++) exp_v[i*PIXEL +: PIXEL] = (i < NUM_PE - 1) ? PIXEL'(i + 1) : 8'd9;
    tests_run++;
    if (ref_out !== exp_v) begin
      tests_failed++;
      $display("FAIL ref_shift: ref_out=%h, required %h", ref_out, exp_v);
    end
    down = rand_row();
    ref_mode = 2'b10; ref_in_down = down;
    tick();
    ref_mode = 2'b00; ref_in_down = rand_row(); ref_in_ext = rand_row();
    tests_run++;
    if (ref_out !== down) begin
      tests_failed++;
      $display("FAIL ref_down: ref_out=%h, required %h", ref_out, down);
    end
    tick(); tick();
    tests_run++;
    if (ref_out !== down) begin
      tests_failed++;
      $display("FAIL ref_hold: ref_out=%h, required %h", ref_out, down);
    end
    ref_m = down;
    $display("[TB] ref modes checked");
  endtask

  task automatic test_reset_abort();
    bit seen;
    fire_start();
    for (int i = 0; i < 4; i++) tick();
    rst = 1;
    tick();
    rst = 0;
    tests_run++;
    if (busy !== 1'b0 || sad_out !== '0 || sad_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_state: busy=%b sad_out=%0d sad_valid=%b, required 0 0 0",
               busy, sad_out, sad_valid);
    end
    tests_run++;
    if (ref_out !== '0) begin
      tests_failed++;
      $display("FAIL abort_ref: ref_out=%h, required 0", ref_out);
    end
    seen = 0;
    for (int i = 0; i < ROWS + 4; i++) begin
      tick();
      if (sad_valid !== 1'b0) seen = 1;
    end
    tests_run++;
    if (seen) begin
      tests_failed++;
      $display("FAIL abort_no_valid: sad_valid seen after abort, required none");
    end
    cur_m[0] = '0; cur_m[1] = '0; ref_m = '0;
    // Banks were cleared: a SAD against a zero reference must now read zero.
    sb_q.push_back('0);
    fire_start();
    for (int i = 0; i < ROWS + 2; i++) tick();
  endtask

  task automatic test_back_to_back();
    int k; bit bb;
    for (int n = 0; n < 4; n++) begin
      load_bank(0, rand_row()); load_bank(1, rand_row());
      ref_mode = 2'b10; ref_in_down = rand_row();
      tick();
      ref_mode = 2'b00; ref_m = ref_in_down;
      curr_bank_rd = n[0];
      sb_q.push_back(SAD_W'(model_sad(cur_m[curr_bank_rd], ref_m)));
      fire_start();
      wait_valid(k, bb);
      tests_run++;
      if (k !== ROWS || bb) begin
        tests_failed++;
        $display("FAIL b2b_latency[%0d]: edges=%0d busy_bad=%b, required %0d 0", n, k, bb, ROWS);
      end
    end
    tick();
  endtask

  initial begin
    rst = 1; curr_load = 0; curr_bank_wr = 0; curr_bank_rd = 0; curr_in = '0;
    ref_mode = 2'b00; ref_in_ext = '0; ref_in_down = '0; ref_in_side = '0;
    start = 0; acc_en = 1;
    test_reset();
    test_basic();
    test_max();
    test_stall();
    test_bank_select();
    test_ref_modes();
    test_reset_abort();
    test_back_to_back();
    tick(); tick();
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_drain: %0d expected results left, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
